ahb_sub_buffered: RTL



---
 rtl/ahb_sub_pkg.sv | 30 +++
 rtl/ahb_sub_buffered_fifo.sv | 66 ++++++
 rtl/ahb_sub_buffered.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sub_pkg.sv
// Shared definitions for the buffered AHB-Lite subordinate: bus encodings,
// register offsets, FSM states and decoded register selects.
package ahb_sub_pkg;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [7:0] OFS_WPUSH  = 8'h00;
    localparam logic [7:0] OFS_IPUSH  = 8'h08;
    localparam logic [7:0] OFS_OUT    = 8'h18;
    localparam logic [7:0] OFS_ERR    = 8'h20;
    localparam logic [7:0] OFS_CTRL   = 8'h22;
    localparam logic [7:0] OFS_STATUS = 8'h23;
    localparam logic [7:0] OFS_ACT    = 8'h24;
    localparam logic [7:0] OFS_LEVEL  = 8'h28;

    typedef enum logic [2:0] {
        IDLE, DATA, WAIT_PUSH, WAIT_OUT, ERR1, ERR2
    } state_t;

    typedef enum logic [3:0] {
        SEL_NONE, SEL_WPUSH, SEL_IPUSH, SEL_OUT, SEL_ERR,
        SEL_CTRL, SEL_STATUS, SEL_ACT, SEL_LEVEL, SEL_BIAS
    } sel_t;

endpackage

// File: rtl/ahb_sub_buffered_fifo.sv
// Pointer + count synchronous FIFO; flush clears all state and wins over pop.
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == LW'(DEPTH));
    assign empty     = (count_r == {LW{1'b0}});
    assign level     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ahb_sub_buffered.sv
// Pipelined AHB-Lite subordinate with bias/control/activation registers and a
// tagged push FIFO toward the compute core; wait states for FIFO full / no result.
module ahb_sub_buffered
    import ahb_sub_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_BIAS   = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  hsel,
    input  logic [ADDR_W-1:0]     haddr,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic                  hwrite,
    input  logic [63:0]           hwdata,
    output logic [63:0]           hrdata,
    output logic                  hready,
    output logic                  hresp,
    output logic [63:0]           push_data,
    output logic                  push_is_weight,
    output logic                  push_valid,
    input  logic                  push_ready,
    input  logic [63:0]           out_data,
    input  logic                  out_valid,
    output logic                  out_ack,
    input  logic [7:0]            status_reg,
    input  logic [15:0]           err_reg,
    output logic [64*NUM_BIAS-1:0] bias_reg,
    output logic [7:0]            ctrl_reg,
    output logic [2:0]            act_mode
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);

    state_t        state_r;
    sel_t          sel_r;
    logic          write_r;
    logic [2:0]    bias_idx_r;
    logic [63:0]   bias_r [NUM_BIAS];
    logic [6:0]    ctrl_r;
    logic [2:0]    act_r;

    sel_t          dec_sel_s;
    logic          dec_ok_s;
    logic          bias_hit_s;
    logic          accept_s;
    logic          data_phase_s;
    logic          is_push_s;
    logic          push_stall_s;
    logic          out_stall_s;
    logic          done_s;
    logic          wr_done_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          flush_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [LW-1:0] fifo_level_s;
    logic [64:0]   fifo_head_s;
    logic          hready_s;
    logic          hresp_s;
    logic [63:0]   rdata_s;

    assign bias_hit_s = (haddr[ADDR_W-1:6] == (ADDR_W-6)'(1)) && (haddr[2:0] == 3'b000)
                        && ({1'b0, haddr[5:3]} < 4'(NUM_BIAS));

    // Address-phase decode: which register and whether size/direction are legal.
    always_comb begin
        dec_sel_s = SEL_NONE;
        dec_ok_s  = 1'b0;
        if (haddr == ADDR_W'(OFS_WPUSH)) begin
            dec_sel_s = SEL_WPUSH;
            dec_ok_s  = (hsize == HSIZE_DWORD);
        end else if (haddr == ADDR_W'(OFS_IPUSH)) begin
            dec_sel_s = SEL_IPUSH;
            dec_ok_s  = (hsize == HSIZE_DWORD);
        end else if (haddr == ADDR_W'(OFS_OUT)) begin
            dec_sel_s = SEL_OUT;
            dec_ok_s  = (hsize == HSIZE_DWORD) && !hwrite;
        end else if (haddr == ADDR_W'(OFS_ERR)) begin
            dec_sel_s = SEL_ERR;
            dec_ok_s  = (hsize == HSIZE_HALF) && !hwrite;
        end else if (haddr == ADDR_W'(OFS_CTRL)) begin
            dec_sel_s = SEL_CTRL;
            dec_ok_s  = (hsize == HSIZE_BYTE);
        end else if (haddr == ADDR_W'(OFS_STATUS)) begin
            dec_sel_s = SEL_STATUS;
            dec_ok_s  = (hsize == HSIZE_BYTE) && !hwrite;
        end else if (haddr == ADDR_W'(OFS_ACT)) begin
            dec_sel_s = SEL_ACT;
            dec_ok_s  = (hsize == HSIZE_BYTE);
        end else if (haddr == ADDR_W'(OFS_LEVEL)) begin
            dec_sel_s = SEL_LEVEL;
            dec_ok_s  = (hsize == HSIZE_BYTE) && !hwrite;
        end else if (bias_hit_s) begin
            dec_sel_s = SEL_BIAS;
            dec_ok_s  = (hsize == HSIZE_DWORD);
        end else begin
            dec_sel_s = SEL_NONE;
            dec_ok_s  = 1'b0;
        end
    end

    assign data_phase_s = (state_r == DATA) || (state_r == WAIT_PUSH) || (state_r == WAIT_OUT);
    assign is_push_s    = write_r && ((sel_r == SEL_WPUSH) || (sel_r == SEL_IPUSH));
    assign push_stall_s = data_phase_s && is_push_s && fifo_full_s;
    assign out_stall_s  = data_phase_s && !write_r && (sel_r == SEL_OUT) && !out_valid;
    assign done_s       = data_phase_s && hready_s;
    assign wr_done_s    = done_s && write_r;
    assign fifo_push_s  = wr_done_s && is_push_s;
    assign flush_s      = wr_done_s && (sel_r == SEL_CTRL) && hwdata[23];
    assign fifo_pop_s   = !fifo_empty_s && push_ready;
    // A new address phase shown during the second error cycle is deliberately dropped.
    assign accept_s     = hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ))
                          && hready_s && (state_r != ERR1) && (state_r != ERR2);

    // Handshake outputs follow the FSM state and the live stall conditions.
    always_comb begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
        case (state_r)
            DATA, WAIT_PUSH, WAIT_OUT: hready_s = !(push_stall_s || out_stall_s);
            ERR1: begin
                hready_s = 1'b0;
                hresp_s  = 1'b1;
            end
            ERR2:    hresp_s = 1'b1;
            default: begin
                hready_s = 1'b1;
                hresp_s  = 1'b0;
            end
        endcase
    end

    // Transfer FSM with registered address-phase information.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r    <= IDLE;
            sel_r      <= SEL_NONE;
            write_r    <= 1'b0;
            bias_idx_r <= 3'd0;
        end else begin
            if (accept_s) begin
                sel_r      <= dec_ok_s ? dec_sel_s : SEL_NONE;
                write_r    <= hwrite;
                bias_idx_r <= haddr[5:3];
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= dec_ok_s ? DATA : ERR1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DATA, WAIT_PUSH, WAIT_OUT: begin
                    if (hready_s) begin
                        if (accept_s) begin
                            state_r <= dec_ok_s ? DATA : ERR1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (push_stall_s) begin
                        state_r <= WAIT_PUSH;
                    end else begin
                        state_r <= WAIT_OUT;
                    end
                end
                ERR1:    state_r <= ERR2;
                ERR2:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Writable register file, updated on the completing data-phase cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ctrl_r <= 7'd0;
            act_r  <= 3'd0;
            for (int i = 0; i < NUM_BIAS; i++) begin
                bias_r[i] <= 64'd0;
            end
        end else if (wr_done_s) begin
            case (sel_r)
                SEL_CTRL: ctrl_r <= hwdata[22:16];
                SEL_ACT:  act_r  <= hwdata[34:32];
                SEL_BIAS: begin
                    for (int i = 0; i < NUM_BIAS; i++) begin
                        if (bias_idx_r == 3'(i)) begin
                            bias_r[i] <= hwdata;
                        end
                    end
                end
                default: ctrl_r <= ctrl_r;
            endcase
        end
    end

    // Read mux; zero outside read data phases and on unused lanes.
    always_comb begin
        rdata_s = 64'd0;
        if (data_phase_s && !write_r) begin
            case (sel_r)
                SEL_OUT:    rdata_s = out_valid ? out_data : 64'd0;
                SEL_ERR:    rdata_s = {48'd0, err_reg};
                SEL_CTRL:   rdata_s = {40'd0, 1'b0, ctrl_r, 16'd0};
                SEL_STATUS: rdata_s = {32'd0, status_reg, 24'd0};
                SEL_ACT:    rdata_s = {24'd0, 5'd0, act_r, 32'd0};
                SEL_LEVEL:  rdata_s = {56'd0, 8'(fifo_level_s)};
                SEL_BIAS: begin
                    for (int i = 0; i < NUM_BIAS; i++) begin
                        if (bias_idx_r == 3'(i)) begin
                            rdata_s = bias_r[i];
                        end else begin
                            rdata_s = rdata_s;
                        end
                    end
                end
                default:    rdata_s = 64'd0;
            endcase
        end else begin
            rdata_s = 64'd0;
        end
    end

    sync_fifo #(
        .WIDTH (65),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (fifo_push_s),
        .push_data ({(sel_r == SEL_WPUSH), hwdata}),
        .pop       (fifo_pop_s),
        .flush     (flush_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s)
    );

    for (genvar g = 0; g < NUM_BIAS; g++) begin : g_bias
        assign bias_reg[64*g +: 64] = bias_r[g];
    end

    assign hrdata         = rdata_s;
    assign hready         = hready_s;
    assign hresp          = hresp_s;
    assign out_ack        = done_s && !write_r && (sel_r == SEL_OUT);
    assign push_data      = fifo_head_s[63:0];
    assign push_is_weight = fifo_head_s[64];
    assign push_valid     = !fifo_empty_s;
    assign ctrl_reg       = {1'b0, ctrl_r};
    assign act_mode       = act_r;

endmodule
